// File: rtl/uart_pkg.sv
// Shared types and constants for the serial receive stage.
// UART_PARITY_EN adds the PARITY state to the receiver state type.
package uart_pkg;

`ifdef UART_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

   localparam int   BAUD_CNT_W     = $clog2(1023 + 1);
   localparam logic SYNC_RESET_VAL = 1'b1;

endpackage

// File: rtl/rx_byte_fifo.sv
// Synchronous FIFO for received bytes; a pop makes room for a push in the same cycle.
// The head output reads 0 while empty.
module rx_byte_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [DATA_W-1:0] i_data,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty
);
   localparam int             PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // NOTE: storage has no reset; the head is masked to 0 while empty instead.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/uart_rx_stage.sv
// Serial receive front end: synchronizer, mid-bit sampling FSM, byte FIFO and error flags.
// Define UART_PARITY_EN for 8E1 framing; the default build receives 8N1.
module uart_rx_stage
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_pin,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       frame_err,
   output logic       parity_err,
   output logic       overrun,
   input  logic       clr_overrun,
   output logic       busy
);
   localparam logic [BAUD_CNT_W-1:0] HALF_BIT_LOAD = BAUD_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BAUD_CNT_W-1:0] FULL_BIT_LOAD = BAUD_CNT_W'(CLKS_PER_BIT - 1);

   logic                  r_sync1;
   logic                  r_sync2;
   rx_state_t             r_state;
   logic [BAUD_CNT_W-1:0] r_baud_cnt;
   logic [2:0]            r_bit_idx;
   logic [7:0]            r_shift;
   logic                  r_frame_err;
   logic                  r_overrun;
   logic                  w_sample;
   logic                  w_par_ok;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_full;
   logic                  w_empty;

`ifdef UART_PARITY_EN
   logic r_parity_bad;
   logic r_parity_err;
   assign w_par_ok   = !r_parity_bad;
   assign parity_err = r_parity_err;
`else
   assign w_par_ok   = 1'b1;
   assign parity_err = 1'b0;
`endif

   // NOTE: the synchronizer resets to the idle-line level so leaving reset never fakes a start bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= SYNC_RESET_VAL;
         r_sync2 <= SYNC_RESET_VAL;
      end else begin
         r_sync1 <= rx_pin;
         r_sync2 <= r_sync1;
      end
   end

   assign w_sample = (r_baud_cnt == '0);
   assign w_push   = (r_state == STOP) && w_sample && r_sync2 && w_par_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_baud_cnt  <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         r_parity_bad <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         // NOTE: error flags default low each cycle so a set lasts exactly one clock.
         r_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
         r_parity_err <= 1'b0;
`endif
         case (r_state)
            IDLE: begin
               if (!r_sync2) begin
                  r_state    <= START;
                  r_baud_cnt <= HALF_BIT_LOAD;
               end
            end
            START: begin
               if (!w_sample) begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
               end else if (!r_sync2) begin
                  r_state    <= DATA;
                  r_baud_cnt <= FULL_BIT_LOAD;
                  r_bit_idx  <= '0;
               end else begin
                  r_state <= IDLE;
               end
            end
            DATA: begin
               if (!w_sample) begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
               end else begin
                  r_shift    <= {r_sync2, r_shift[7:1]};
                  r_baud_cnt <= FULL_BIT_LOAD;
                  r_bit_idx  <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
                     r_state <= PARITY;
`else
                     r_state <= STOP;
`endif
                  end
               end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
               if (!w_sample) begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
               end else begin
                  r_parity_bad <= (r_sync2 != ^r_shift);
                  r_baud_cnt   <= FULL_BIT_LOAD;
                  r_state      <= STOP;
               end
            end
`endif
            STOP: begin
               if (!w_sample) begin
                  r_baud_cnt <= r_baud_cnt - 1'b1;
               end else begin
                  // Return to IDLE at mid stop bit so the next start edge is caught early.
                  r_state <= IDLE;
                  if (!r_sync2) r_frame_err <= 1'b1;
`ifdef UART_PARITY_EN
                  else if (r_parity_bad) r_parity_err <= 1'b1;
`endif
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign w_pop = m_valid && m_ready;

   // A new overrun outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (rst)                               r_overrun <= 1'b0;
      else if (w_push && w_full && !w_pop)   r_overrun <= 1'b1;
      else if (clr_overrun)                  r_overrun <= 1'b0;
   end

   rx_byte_fifo #(
      .DATA_W (8),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_pop   (m_ready),
      .i_data  (r_shift),
      .o_data  (m_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign m_valid   = !w_empty;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;
   assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_stage.sv
// Bench for uart_rx_stage: frame-level reference model with a per-cycle compare, plus
// literal checks on directed scenarios. Honours UART_PARITY_EN like the design.
module tb_uart_rx_stage;
   localparam int C     = 16;
   localparam int DEPTH = 4;
`ifdef UART_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_pin = 1'b1;
   logic       m_ready = 1'b0;
   logic       clr_overrun = 1'b0;
   logic [7:0] m_data;
   logic       m_valid, frame_err, parity_err, overrun, busy;

   uart_rx_stage #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .rx_pin      (rx_pin),
      .m_data      (m_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .frame_err   (frame_err),
      .parity_err  (parity_err),
      .overrun     (overrun),
      .clr_overrun (clr_overrun),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: frame outcomes are scheduled by edge number when a frame is sent.
   int         edge_n = 0;
   logic [7:0] q[$];
   bit         exp_ovr, exp_busy, exp_ferr, exp_perr;
   bit         model_live = 0;
   int         push_at[int];
   bit         ferr_at[int], perr_at[int], bset[int], bclr[int];

   initial forever begin
      @(posedge clk);
      edge_n++;
      if (rst) begin
         q.delete();
         push_at.delete(); ferr_at.delete(); perr_at.delete(); bset.delete(); bclr.delete();
         exp_ovr = 0; exp_busy = 0; exp_ferr = 0; exp_perr = 0;
         model_live = 1;
      end else begin
         bit pop, ovr_set;
         pop     = (q.size() != 0) && m_ready;
         ovr_set = 0;
         if (pop) void'(q.pop_front());
         if (push_at.exists(edge_n)) begin
            if (q.size() == DEPTH) ovr_set = 1;
            else q.push_back(8'(push_at[edge_n]));
         end
         if (ovr_set) exp_ovr = 1;
         else if (clr_overrun) exp_ovr = 0;
         if (bset.exists(edge_n)) exp_busy = 1;
         if (bclr.exists(edge_n)) exp_busy = 0;
         exp_ferr = ferr_at.exists(edge_n);
         exp_perr = perr_at.exists(edge_n);
      end
   end

   initial forever begin
      @(negedge clk);
      if (model_live) begin
         check("m_valid", m_valid, q.size() != 0);
         if (q.size() != 0) check("m_data", m_data, q[0]);
         check("overrun", overrun, exp_ovr);
         check("frame_err", frame_err, exp_ferr);
         check("parity_err", parity_err, exp_perr);
         check("busy", busy, exp_busy);
      end
   end

   // Observed traffic, used for literal expectations.
   logic [7:0] popped[$];
   int ferr_cnt = 0, perr_cnt = 0, vcyc = 0;
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (m_valid && m_ready) popped.push_back(m_data);
         if (m_valid) vcyc++;
         if (frame_err) ferr_cnt++;
         if (parity_err) perr_cnt++;
      end
   end

   bit rnd_en = 0;
   int ready_pct = 0;
   initial forever begin
      @(posedge clk); #1;
      if (rnd_en) begin
         m_ready     = ($urandom_range(0, 99) < ready_pct);
         clr_overrun = ($urandom_range(0, 15) == 0);
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Drive one frame starting just after edge k; the FSM sees the start at k+3 and the
   // stop sample lands C/2 + (9+P)*C edges later.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic par_ok,
                             input bit pop_at_stop, input int gap);
      logic [10:0] frame;
      int k, s_edge;
      k      = edge_n;
      s_edge = k + 3 + C / 2 + (9 + P) * C;
      frame  = '1;
      frame[0]   = 1'b0;
      frame[8:1] = data;
      if (P == 1) frame[9] = (^data) ^ !par_ok;
      frame[9 + P] = stop_bit;
      bset[k + 3]  = 1;
      bclr[s_edge] = 1;
      if (!stop_bit) begin
         ferr_at[s_edge]         = 1;
         // The still-low stop bit is seen as a new start, then rejected at half-bit.
         bset[s_edge + 1]         = 1;
         bclr[s_edge + 1 + C / 2] = 1;
      end else if (P == 1 && !par_ok) begin
         perr_at[s_edge] = 1;
      end else begin
         push_at[s_edge] = int'(data);
      end
      for (int b = 0; b < 10 + P; b++) begin
         rx_pin = frame[b];
         for (int c = 0; c < C; c++) begin
            tick(1);
            if (pop_at_stop) m_ready = (edge_n == s_edge - 1);
         end
      end
      rx_pin = 1'b1;
      tick(gap + (stop_bit ? 0 : C));
   endtask

   initial begin
      int p0, v0, f0, e0;
      tick(4);
      check("reset m_valid", m_valid, 0);
      check("reset m_data", m_data, 0);
      check("reset busy", busy, 0);
      check("reset overrun", overrun, 0);
      check("reset frame_err", frame_err, 0);
      rst = 1'b0;
      tick(5);

      // Single byte, consumer always ready
      m_ready = 1'b1;
      p0 = popped.size(); v0 = vcyc;
      send_frame(8'hA5, 1'b1, 1'b1, 0, 10);
      check("a5 count", popped.size() - p0, 1);
      check("a5 data", popped[$], 8'hA5);
      check("a5 valid cycles", vcyc - v0, 1);
      check("a5 no ferr", ferr_cnt, 0);

      // Bad stop bit
      p0 = popped.size(); v0 = vcyc; f0 = ferr_cnt;
      send_frame(8'h3C, 1'b0, 1'b1, 0, 10);
      check("3c ferr pulses", ferr_cnt - f0, 1);
      check("3c no valid", vcyc - v0, 0);
      check("3c busy low", busy, 0);

      // Short glitch in idle
      begin
         int k;
         k = edge_n;
         bset[k + 3] = 1;
         bclr[k + 3 + C / 2] = 1;
         rx_pin = 1'b0;
         tick(4);
         rx_pin = 1'b1;
         tick(C + 4);
      end
      check("glitch no valid", vcyc - v0, 0);
      check("glitch no ferr", ferr_cnt - f0, 1);
      check("glitch busy low", busy, 0);

      // Overrun: five bytes into a four-entry FIFO
      m_ready = 1'b0;
      for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1, 1'b1, 0, 2);
      check("ovr flag", overrun, 1);
      check("ovr valid", m_valid, 1);
      check("ovr head", m_data, 8'h01);
      p0 = popped.size();
      m_ready = 1'b1;
      tick(6);
      m_ready = 1'b0;
      check("ovr drained", popped.size() - p0, 4);
      for (int i = 0; i < 4; i++) check("ovr drain data", popped[p0 + i], 8'(i + 1));
      check("ovr still set", overrun, 1);
      clr_overrun = 1'b1;
      tick(1);
      clr_overrun = 1'b0;
      check("ovr cleared", overrun, 0);

      // Full FIFO with a pop in the stop-sample cycle of a fifth byte
      p0 = popped.size();
      for (int b = 0; b < 4; b++) send_frame(8'h11 + 8'(b), 1'b1, 1'b1, 0, 2);
      send_frame(8'h15, 1'b1, 1'b1, 1, 4);
      check("fullpop no ovr", overrun, 0);
      m_ready = 1'b1;
      tick(6);
      m_ready = 1'b0;
      check("fullpop count", popped.size() - p0, 5);
      for (int i = 0; i < 5; i++) check("fullpop data", popped[p0 + i], 8'h11 + 8'(i));

`ifdef UART_PARITY_EN
      m_ready = 1'b1;
      p0 = popped.size(); e0 = perr_cnt;
      send_frame(8'h07, 1'b1, 1'b0, 0, 6);
      check("par bad pulse", perr_cnt - e0, 1);
      check("par bad no push", popped.size() - p0, 0);
      send_frame(8'h07, 1'b1, 1'b1, 0, 6);
      check("par good push", popped.size() - p0, 1);
      check("par good data", popped[$], 8'h07);
      check("par good no pulse", perr_cnt - e0, 1);
`else
      e0 = perr_cnt;
`endif

      // Randomized traffic against the model
      rnd_en = 1;
      for (int n = 0; n < 40; n++) begin
         ready_pct = (n < 20) ? 1 : 40;
         send_frame(8'($urandom), ($urandom_range(0, 9) != 0), ($urandom_range(0, 5) != 0),
                    0, $urandom_range(0, 20));
      end
      rnd_en = 0;
      #1;
      clr_overrun = 1'b0;
      m_ready = 1'b1;
      tick(20);
      check("end busy", busy, 0);
      check("end drained", m_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
